// File: rtl/mem_ctrl.sv
// Memory controller: a CPU-facing load/store port in front of a small
// 16-bit RAM, a write-only LED register and a read-only switch port.
// Each access completes with a four-phase mem_ready handshake.
module mem_ctrl #(
    parameter int          RAM_WORDS = 256,
    parameter logic [8:0]  LED_ADDR  = 9'h100,
    parameter logic [8:0]  SW_ADDR   = 9'h140,
    parameter int          RD_WAIT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    input  logic [15:0] sw_in,
    output logic [15:0] read_data,
    output logic        mem_ready,
    output logic [15:0] led_out,
    output logic        bad_addr
);

    localparam int          RAM_AW      = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [2:0]  RD_WAIT_CNT = 3'(RD_WAIT);
    localparam logic [1:0]  CMD_READ    = 2'b01;
    localparam logic [1:0]  CMD_WRITE   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [RAM_AW-1:0]   addr_q, addr_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [15:0]         read_data_q, read_data_d;
    logic                mem_ready_q, mem_ready_d;
    logic [15:0]         led_q, led_d;
    logic                bad_q, bad_d;
    logic [15:0]         sw_meta_q, sw_sync_q;

    logic [15:0]         ram [RAM_WORDS];
    logic                ram_we;
    logic [RAM_AW-1:0]   ram_widx;
    logic [15:0]         ram_wdata;

    logic                in_ram;
    logic                cmd_none;

    // Full 9-bit decode, so nothing above the RAM aliases back into it.
    assign in_ram   = (32'(mem_addr) < 32'(RAM_WORDS));
    assign cmd_none = (mem_cmd != CMD_READ) && (mem_cmd != CMD_WRITE);

    // Next-state and datapath decisions; commands are only looked at in IDLE.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        mem_ready_d = mem_ready_q;
        led_d       = led_q;
        bad_d       = bad_q;
        ram_we      = 1'b0;
        ram_widx    = mem_addr[RAM_AW-1:0];
        ram_wdata   = write_data;

        case (state_q)
            S_IDLE: begin
                if (mem_cmd == CMD_READ) begin
                    if (in_ram) begin
                        addr_d  = mem_addr[RAM_AW-1:0];
                        cnt_d   = RD_WAIT_CNT;
                        state_d = S_RD_WAIT;
                    end else if (mem_addr == SW_ADDR) begin
                        read_data_d = sw_sync_q;
                        mem_ready_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        read_data_d = 16'h0000;
                        bad_d       = 1'b1;
                        mem_ready_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end else if (mem_cmd == CMD_WRITE) begin
                    if (in_ram) begin
                        ram_we = 1'b1;
                    end else if (mem_addr == LED_ADDR) begin
                        led_d = write_data;
                    end else begin
                        bad_d = 1'b1;
                    end
                    mem_ready_d = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_RD_WAIT: begin
                if (cnt_q == 3'd0) begin
                    read_data_d = ram[addr_q];
                    mem_ready_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            S_DONE: begin
                mem_ready_d = 1'b1;
                if (cmd_none) begin
                    mem_ready_d = 1'b0;
                    bad_d       = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, output registers and the switch synchroniser, with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= 3'd0;
            read_data_q <= 16'h0000;
            mem_ready_q <= 1'b0;
            led_q       <= 16'h0000;
            bad_q       <= 1'b0;
            sw_meta_q   <= 16'h0000;
            sw_sync_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            mem_ready_q <= mem_ready_d;
            led_q       <= led_d;
            bad_q       <= bad_d;
            sw_meta_q   <= sw_in;
            sw_sync_q   <= sw_meta_q;
        end
    end

    // RAM array is never cleared; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (ram_we && reset) begin
            ram[ram_widx] <= ram_wdata;
        end
    end

    assign read_data = read_data_q;
    assign mem_ready = mem_ready_q;
    assign led_out   = led_q;
    assign bad_addr  = bad_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: the stimulus process pushes the expected
// completion of every access, and a monitor pops it when mem_ready rises.
module tb_mem_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] sw_in;
    logic [15:0] read_data;
    logic        mem_ready;
    logic [15:0] led_out;
    logic        bad_addr;

    localparam logic [1:0] NONE  = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;

    typedef struct {
        logic [15:0] data;
        logic        bad;
        int          lat;
        int          start;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;
    int   cycle  = 0;

    mem_ctrl #(
        .RAM_WORDS (256),
        .LED_ADDR  (9'h100),
        .SW_ADDR   (9'h140),
        .RD_WAIT   (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .sw_in      (sw_in),
        .read_data  (read_data),
        .mem_ready  (mem_ready),
        .led_out    (led_out),
        .bad_addr   (bad_addr)
    );

    // Free-running clock and an edge counter used for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Issue one access, push its expected completion, then finish the handshake.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [8:0] addr,
                                 input logic [15:0] wd, input logic [15:0] expData,
                                 input logic expBad, input int expLat, input int hold);
        exp_t e;
        bit   seen;
        @(negedge clk);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = wd;
        e.data  = expData;
        e.bad   = expBad;
        e.lat   = expLat;
        e.start = cycle;
        expQ.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("ready_timeout", 16'd0, 16'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("ready_hold", 16'(mem_ready), 16'd1);
        end
        mem_cmd = NONE;
        @(negedge clk);
        checkOutput("ready_clear", 16'(mem_ready), 16'd0);
        checkOutput("bad_clear", 16'(bad_addr), 16'd0);
    endtask

    // Monitor: on each rising mem_ready, compare against the oldest expectation.
    initial begin
        exp_t e;
        logic prevReady;
        prevReady = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_ready && !prevReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_ready", 16'd1, 16'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("read_data", read_data, e.data);
                    checkOutput("bad_addr", 16'(bad_addr), 16'(e.bad));
                    checkOutput("latency", 16'(cycle - e.start), 16'(e.lat));
                end
            end
            prevReady = mem_ready;
        end
    end

    // Directed sequence.
    initial begin
        reset      = 1'b0;
        mem_cmd    = NONE;
        mem_addr   = 9'h000;
        write_data = 16'h0000;
        sw_in      = 16'h0000;
        repeat (3) @(negedge clk);
        checkOutput("rst_read_data", read_data, 16'h0000);
        checkOutput("rst_ready", 16'(mem_ready), 16'd0);
        checkOutput("rst_led", led_out, 16'h0000);
        checkOutput("rst_bad", 16'(bad_addr), 16'd0);
        reset = 1'b1;

        // Basic RAM write/read round trip.
        applyStimulus(WRITE, 9'h020, 16'h1111, 16'h0000, 1'b0, 1, 0);
        applyStimulus(WRITE, 9'h005, 16'hBEEF, 16'h0000, 1'b0, 1, 0);
        applyStimulus(READ,  9'h005, 16'h0000, 16'hBEEF, 1'b0, 3, 0);

        // LED write with the command held across DONE.
        applyStimulus(WRITE, 9'h100, 16'h00A5, 16'hBEEF, 1'b0, 1, 3);
        checkOutput("led_value", led_out, 16'h00A5);

        // Switch read through the synchroniser.
        @(negedge clk);
        sw_in = 16'h1234;
        repeat (3) @(negedge clk);
        applyStimulus(READ,  9'h140, 16'h0000, 16'h1234, 1'b0, 1, 0);

        // Unmapped accesses and aliasing guard on 9'h040.
        applyStimulus(WRITE, 9'h040, 16'h4040, 16'h1234, 1'b0, 1, 0);
        applyStimulus(READ,  9'h1FF, 16'h0000, 16'h0000, 1'b1, 1, 0);
        applyStimulus(WRITE, 9'h140, 16'h5555, 16'h0000, 1'b1, 1, 0);
        checkOutput("led_unchanged", led_out, 16'h00A5);
        applyStimulus(READ,  9'h100, 16'h0000, 16'h0000, 1'b1, 1, 0);
        applyStimulus(READ,  9'h040, 16'h0000, 16'h4040, 1'b0, 3, 0);

        // RAM range edges.
        applyStimulus(WRITE, 9'h0FF, 16'hABCD, 16'h4040, 1'b0, 1, 0);
        applyStimulus(READ,  9'h0FF, 16'h0000, 16'hABCD, 1'b0, 3, 0);
        applyStimulus(WRITE, 9'h000, 16'h0F0F, 16'hABCD, 1'b0, 1, 0);
        applyStimulus(READ,  9'h000, 16'h0000, 16'h0F0F, 1'b0, 3, 0);

        // Reset while a write is presented: the write must be dropped.
        @(negedge clk);
        reset      = 1'b0;
        mem_cmd    = WRITE;
        mem_addr   = 9'h020;
        write_data = 16'hDEAD;
        repeat (2) @(negedge clk);
        checkOutput("rst2_read_data", read_data, 16'h0000);
        checkOutput("rst2_led", led_out, 16'h0000);
        reset   = 1'b1;
        mem_cmd = NONE;
        applyStimulus(READ,  9'h020, 16'h0000, 16'h1111, 1'b0, 3, 0);

        // Reset in the middle of a RAM read wait.
        @(negedge clk);
        mem_cmd  = READ;
        mem_addr = 9'h005;
        @(negedge clk);
        reset   = 1'b0;
        mem_cmd = NONE;
        @(negedge clk);
        checkOutput("rdwait_rst_ready", 16'(mem_ready), 16'd0);
        checkOutput("rdwait_rst_data", read_data, 16'h0000);
        reset = 1'b1;
        applyStimulus(READ,  9'h005, 16'h0000, 16'hBEEF, 1'b0, 3, 0);

        // Write held for 10 cycles with changing data, released with 2'b11.
        begin
            exp_t e;
            @(negedge clk);
            mem_cmd    = WRITE;
            mem_addr   = 9'h010;
            write_data = 16'h1000;
            e.data  = 16'hBEEF;
            e.bad   = 1'b0;
            e.lat   = 1;
            e.start = cycle;
            expQ.push_back(e);
            for (int i = 1; i < 10; i++) begin
                @(negedge clk);
                checkOutput("held_ready", 16'(mem_ready), 16'd1);
                write_data = 16'h1000 + 16'(i);
            end
            mem_cmd = 2'b11;
            @(negedge clk);
            checkOutput("held_release", 16'(mem_ready), 16'd0);
            @(negedge clk);
            checkOutput("cmd11_idle", 16'(mem_ready), 16'd0);
            mem_cmd = NONE;
        end
        applyStimulus(READ,  9'h010, 16'h0000, 16'h1000, 1'b0, 3, 0);

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", 16'(expQ.size()), 16'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Safety net in case the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter RAM_WORDS, 256, number of 16-bit RAM words, mapped at mem_addr 9'h000 to RAM_WORDS-1.
REQ-002 Parameter LED_ADDR, 9'h100, write-only LED register address.
REQ-003 Parameter SW_ADDR, 9'h140, read-only switch port address.
REQ-004 Parameter RD_WAIT, 1, extra RAM read wait cycles, legal range 0..7.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock; only clock in the block.
REQ-007 reset  in  1  synchronous active-low reset, sampled on rising clk.
REQ-008 mem_cmd  in  2  command: 00 NONE, 01 READ, 10 WRITE; 11 is treated as NONE.
REQ-009 mem_addr  in  9  word address from the CPU.
REQ-010 write_data  in  16  store data from the CPU.
REQ-011 sw_in  in  16  switch inputs, asynchronous to the block.
REQ-012 read_data  out  16  load data returned to the CPU, registered.
REQ-013 mem_ready  out  1  access complete, registered.
REQ-014 led_out  out  16  LED register contents, registered.
REQ-015 bad_addr  out  1  the completed access targeted an unmapped address, registered.

Function
REQ-016 States: IDLE, RD_WAIT, DONE; encoding is free.
REQ-017 mem_cmd and mem_addr are sampled only in IDLE; changes in any other state are ignored until the block returns to IDLE.
REQ-018 sw_in is synchronised through a 2-flop synchroniser; SW reads return the synchronised value.
REQ-019 IDLE, READ to RAM range:
- latch the address;
- load the wait counter with RD_WAIT;
- go to RD_WAIT.
REQ-020 RD_WAIT:
- decrement the counter each cycle;
- at count 0, register RAM[latched addr] into read_data and go to DONE.
- With RD_WAIT=0, read_data is valid and mem_ready rises 2 cycles after the command is sampled.
REQ-021 IDLE, READ to SW_ADDR: register the synchronised switches into read_data and go to DONE (mem_ready high 1 cycle after sampling).
REQ-022 IDLE, WRITE to RAM range: write RAM[mem_addr] <= write_data on the sampling edge, then go to DONE.
REQ-023 IDLE, WRITE to LED_ADDR: led_out <= write_data on the sampling edge, then go to DONE.
REQ-024 Unmapped accesses (READ of LED_ADDR, WRITE of SW_ADDR, any other address):
- go to DONE with bad_addr=1;
- a read sets read_data to 16'h0000;
- a write changes nothing.
REQ-025 DONE, four-phase handshake:
- mem_ready=1 for as long as the block stays in DONE;
- stay in DONE while mem_cmd != NONE;
- go to IDLE on the first cycle mem_cmd == NONE;
- mem_ready and bad_addr clear on entering IDLE.
REQ-026 A command held across DONE is never executed twice; a new access needs a NONE cycle in between.
REQ-027 read_data holds its value until the next read completes; writes do not change it.
REQ-028 RAM contents are undefined after power-up and are not cleared by reset.
REQ-029 Address decode uses all 9 bits; there is no aliasing.

Reset
REQ-030 When reset=0 at a rising edge:
- state <= IDLE;
- read_data <= 0, mem_ready <= 0, led_out <= 0, bad_addr <= 0;
- wait counter <= 0, synchroniser flops <= 0.
REQ-031 Reset takes priority over every transition, including mid-RD_WAIT and DONE.
REQ-032 A RAM write whose sampling edge coincides with reset=0 is not performed.
REQ-033 The first command is sampled on the first edge with reset=1.

Verification
REQ-034 WRITE addr 9'h005, data 16'hBEEF, then NONE, then READ 9'h005 with RD_WAIT=1:
- read_data = 16'hBEEF;
- mem_ready rises 3 cycles after the READ is sampled.
REQ-035 WRITE 9'h100 data 16'h00A5:
- led_out = 16'h00A5 one cycle later;
- mem_ready held until mem_cmd = NONE, then 0 the next cycle.
REQ-036 sw_in = 16'h1234 stable for 3 cycles, then READ 9'h140:
- read_data = 16'h1234;
- mem_ready rises 1 cycle after sampling.
REQ-037 READ 9'h1FF:
- bad_addr=1 and read_data=16'h0000;
- WRITE 9'h140 leaves led_out and RAM unchanged, with bad_addr=1.
REQ-038 Reset=0 asserted in RD_WAIT: next cycle state IDLE, mem_ready=0, read_data=0; a subsequent READ completes normally.
REQ-039 mem_cmd held at WRITE 9'h010 for 10 cycles with write_data changing each cycle:
- RAM[9'h010] = the data value at the sampling edge only;
- mem_ready stays 1 throughout DONE.
